// File: rtl/board_io_bridge.sv
// -----------------------------------------------------------------------------
// board_io_bridge
//
// Glue between a board and a small video/game design running on a divided
// clock enable:
//   * clock divider producing a one-cycle clk_en pulse every CLK_DIV clocks
//   * per-button 2-flop synchroniser, optional debounce, and rising-edge pulse
//   * colour expansion from COLOR_IN_W to COLOR_OUT_W bits per channel by
//     MSB-first bit replication, registered together with the syncs on clk_en
//
// Configuration macro:
//   BOARD_IO_DEBOUNCE_EN  when defined, each button has a stability counter and
//                         btn_level only changes after DEBOUNCE_CYCLES
//                         consecutive cycles of disagreement. When undefined,
//                         btn_level is the synchroniser output directly.
//
// Ports:
//   clock                          system clock, all flops on rising edge
//   reset                          asynchronous active-high reset
//   btn_raw   [NUM_BTN-1:0]        asynchronous button pins
//   clk_en                         one-cycle enable every CLK_DIV clocks
//   btn_level [NUM_BTN-1:0]        debounced button state
//   btn_press [NUM_BTN-1:0]        one-cycle pulse on each debounced 0->1
//   red_in/green_in/blue_in        design colour, COLOR_IN_W bits each
//   hsync_in/vsync_in              design syncs
//   red_out/green_out/blue_out     expanded colour, COLOR_OUT_W bits each
//   hsync_out/vsync_out            syncs, registered alongside the colour
// -----------------------------------------------------------------------------
module board_io_bridge #(
  parameter int CLK_DIV         = 2,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COLOR_IN_W      = 2,
  parameter int COLOR_OUT_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     btn_raw,
  output logic                   clk_en,
  output logic [NUM_BTN-1:0]     btn_level,
  output logic [NUM_BTN-1:0]     btn_press,
  input  logic [COLOR_IN_W-1:0]  red_in,
  input  logic [COLOR_IN_W-1:0]  green_in,
  input  logic [COLOR_IN_W-1:0]  blue_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [COLOR_OUT_W-1:0] red_out,
  output logic [COLOR_OUT_W-1:0] green_out,
  output logic [COLOR_OUT_W-1:0] blue_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  // ---------------------------------------------------------------------------
  // Clock-enable divider
  // ---------------------------------------------------------------------------
  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_clk_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // With CLK_DIV=1 the counter is stuck at 0 == DIV_LAST, so the enable is
  // permanently high, which is exactly the "every clock" behaviour wanted.
  assign w_clk_en = (r_div_cnt == DIV_LAST);
  assign clk_en   = w_clk_en;

  // ---------------------------------------------------------------------------
  // Button synchroniser: two flops before anything else looks at the pins
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] r_sync_meta;
  logic [NUM_BTN-1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= btn_raw;
      r_sync      <= r_sync_meta;
    end
  end

`ifdef BOARD_IO_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debounce: a per-channel counter runs while the synchronised value disagrees
  // with the accepted level and clears the moment they agree again. When the
  // counter has already counted DEBOUNCE_CYCLES-1 and the disagreement is still
  // present, the level flips and the counter restarts. This means the level
  // changes after exactly DEBOUNCE_CYCLES consecutive disagreeing cycles.
  // ---------------------------------------------------------------------------
  localparam int               DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0]    r_db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;

  // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared
  // by reset like any other state; partial counts must not survive a reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_level <= '0;
      r_press <= '0;
    end else begin
      r_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= ~r_level[i];
          // Pulse only when the accepted level goes 0 -> 1; it lands in the
          // same cycle as the new level.
          r_press[i]  <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;
`else
  // ---------------------------------------------------------------------------
  // No debounce: the synchroniser output is the button level. The press pulse
  // is computed one stage early (meta=1, sync=0) so it lines up with the first
  // cycle of btn_level=1.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] r_press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_press <= '0;
    end else begin
      r_press <= r_sync_meta & ~r_sync;
    end
  end

  assign btn_level = r_sync;
  assign btn_press = r_press;
`endif

  // ---------------------------------------------------------------------------
  // Colour expansion: output bit (OUT_W-1-i) takes input bit (IN_W-1 - i%IN_W),
  // so the input pattern repeats from the MSB down and is cut off at the LSB.
  // All-zeros stays 0 and all-ones becomes full scale.
  // ---------------------------------------------------------------------------
  function automatic logic [COLOR_OUT_W-1:0] expand_color(
    input logic [COLOR_IN_W-1:0] c
  );
    logic [COLOR_OUT_W-1:0] result;
    result = '0;
    for (int i = 0; i < COLOR_OUT_W; i++) begin
      result[COLOR_OUT_W-1-i] = c[COLOR_IN_W-1-(i % COLOR_IN_W)];
    end
    return result;
  endfunction

  logic [COLOR_OUT_W-1:0] w_red_exp;
  logic [COLOR_OUT_W-1:0] w_green_exp;
  logic [COLOR_OUT_W-1:0] w_blue_exp;

  assign w_red_exp   = expand_color(red_in);
  assign w_green_exp = expand_color(green_in);
  assign w_blue_exp  = expand_color(blue_in);

  // ---------------------------------------------------------------------------
  // Output stage: colour and syncs share one enable-gated register so they
  // always describe the same pixel.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (w_clk_en) begin
      red_out   <= w_red_exp;
      green_out <= w_green_exp;
      blue_out  <= w_blue_exp;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_board_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_board_io_bridge
//
// Directed bench for board_io_bridge. Two instances:
//   u_dut   CLK_DIV=2, 4 buttons, DEBOUNCE_CYCLES=8, 2->4 bit colour
//   u_dut1  CLK_DIV=1, 1 button,  DEBOUNCE_CYCLES=1, 3->8 bit colour
// Button latency expectations follow BOARD_IO_DEBOUNCE_EN: 2+8 clocks with
// debounce, 2 clocks without. Inputs are driven and outputs sampled 1 ns after
// a rising edge.
// -----------------------------------------------------------------------------
module tb_board_io_bridge;

`ifdef BOARD_IO_DEBOUNCE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 2;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [3:0] btn_raw;
  logic       clk_en;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [1:0] red_in, green_in, blue_in;
  logic       hsync_in, vsync_in;
  logic [3:0] red_out, green_out, blue_out;
  logic       hsync_out, vsync_out;

  logic [0:0] btn_raw_1;
  logic       clk_en_1;
  logic [0:0] btn_level_1;
  logic [0:0] btn_press_1;
  logic [2:0] red_in_1, green_in_1, blue_in_1;
  logic       hsync_in_1, vsync_in_1;
  logic [7:0] red_out_1, green_out_1, blue_out_1;
  logic       hsync_out_1, vsync_out_1;

  board_io_bridge #(
    .CLK_DIV(2), .NUM_BTN(4), .DEBOUNCE_CYCLES(8), .COLOR_IN_W(2), .COLOR_OUT_W(4)
  ) u_dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .clk_en(clk_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  board_io_bridge #(
    .CLK_DIV(1), .NUM_BTN(1), .DEBOUNCE_CYCLES(1), .COLOR_IN_W(3), .COLOR_OUT_W(8)
  ) u_dut1 (
    .clock(clock), .reset(reset), .btn_raw(btn_raw_1), .clk_en(clk_en_1),
    .btn_level(btn_level_1), .btn_press(btn_press_1),
    .red_in(red_in_1), .green_in(green_in_1), .blue_in(blue_in_1),
    .hsync_in(hsync_in_1), .vsync_in(vsync_in_1),
    .red_out(red_out_1), .green_out(green_out_1), .blue_out(blue_out_1),
    .hsync_out(hsync_out_1), .vsync_out(vsync_out_1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(btn_level), 32'h0);
    check({tag, "_press"}, 32'(btn_press), 32'h0);
    check({tag, "_red"},   32'(red_out),   32'h0);
    check({tag, "_green"}, 32'(green_out), 32'h0);
    check({tag, "_blue"},  32'(blue_out),  32'h0);
    check({tag, "_hsync"}, 32'(hsync_out), 32'h0);
    check({tag, "_vsync"}, 32'(vsync_out), 32'h0);
    check({tag, "_clken"}, 32'(clk_en),    32'h0);
  endtask

  initial begin
    int presses;

    // ---- reset state, with busy inputs to show reset dominates -------------
    reset      = 1'b1;
    btn_raw    = 4'hF;
    red_in     = 2'b11;
    green_in   = 2'b11;
    blue_in    = 2'b11;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    btn_raw_1  = 1'b0;
    red_in_1   = 3'b101;
    green_in_1 = 3'b111;
    blue_in_1  = 3'b011;
    hsync_in_1 = 1'b1;
    vsync_in_1 = 1'b0;
    #1;
    check_all_zero("rst0");
    step(3);
    check_all_zero("rst_hold");

    btn_raw  = 4'h0;
    red_in   = 2'b00;
    green_in = 2'b00;
    blue_in  = 2'b00;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    reset    = 1'b0;

    // ---- divider: first enable CLK_DIV-1 clocks after release --------------
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check($sformatf("clken_div2_c%0d", k), 32'(clk_en), 32'(k % 2));
      check($sformatf("clken_div1_c%0d", k), 32'(clk_en_1), 32'h1);
    end

    // ---- colour expansion and alignment ------------------------------------
    // Divider count is now 0, so the next edge is not an enable edge.
    red_in   = 2'b01;
    green_in = 2'b10;
    blue_in  = 2'b11;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    step(1);
    check("col_preload_red",   32'(red_out),   32'h0);
    check("col_preload_hsync", 32'(hsync_out), 32'h0);
    step(1);
    check("col_red_01",   32'(red_out),   32'b0101);
    check("col_green_10", 32'(green_out), 32'b1010);
    check("col_blue_11",  32'(blue_out),  32'b1111);
    check("col_hsync",    32'(hsync_out), 32'h1);
    check("col_vsync",    32'(vsync_out), 32'h0);

    red_in   = 2'b00;
    green_in = 2'b11;
    blue_in  = 2'b01;
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    step(1);
    check("col_hold_red",   32'(red_out),   32'b0101);
    check("col_hold_vsync", 32'(vsync_out), 32'h0);
    step(1);
    check("col_red_00",   32'(red_out),   32'b0000);
    check("col_green_11", 32'(green_out), 32'b1111);
    check("col_blue_01",  32'(blue_out),  32'b0101);
    check("col_hsync0",   32'(hsync_out), 32'h0);
    check("col_vsync1",   32'(vsync_out), 32'h1);

    // 3 -> 8 bit replication on the CLK_DIV=1 instance
    check("col8_red_101",   32'(red_out_1),   32'hB6);
    check("col8_green_111", 32'(green_out_1), 32'hFF);
    check("col8_blue_011",  32'(blue_out_1),  32'h6D);
    check("col8_hsync",     32'(hsync_out_1), 32'h1);

    // ---- single button rise and fall ---------------------------------------
    red_in = 2'b10;
    btn_raw = 4'b1000;
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1);
      check($sformatf("b3_rise_level_c%0d", k), 32'(btn_level), (k >= LAT) ? 32'h8 : 32'h0);
      check($sformatf("b3_rise_press_c%0d", k), 32'(btn_press), (k == LAT) ? 32'h8 : 32'h0);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1);
      check($sformatf("b3_fall_level_c%0d", k), 32'(btn_level), (k >= LAT) ? 32'h0 : 32'h8);
      check($sformatf("b3_fall_press_c%0d", k), 32'(btn_press), 32'h0);
    end

`ifdef BOARD_IO_DEBOUNCE_EN
    // ---- glitch shorter than the debounce interval -------------------------
    btn_raw = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("glitch_on_level_c%0d", k), 32'(btn_level), 32'h0);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("glitch_off_level_c%0d", k), 32'(btn_level), 32'h0);
      check($sformatf("glitch_off_press_c%0d", k), 32'(btn_press), 32'h0);
    end
`endif

    // ---- simultaneous rise on two channels ---------------------------------
    btn_raw = 4'b0101;
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1);
      check($sformatf("b02_level_c%0d", k), 32'(btn_level), (k >= LAT) ? 32'h5 : 32'h0);
      check($sformatf("b02_press_c%0d", k), 32'(btn_press), (k == LAT) ? 32'h5 : 32'h0);
    end
    btn_raw = 4'b0000;
    step(LAT + 2);
    check("b02_released_level", 32'(btn_level), 32'h0);

    // ---- reset in the middle of a debounce, button held throughout ---------
    btn_raw = 4'b1000;
    step(7);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all_zero("midrst_hold");
    reset = 1'b0;
    presses = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(1);
      if (btn_press[3]) presses++;
      check($sformatf("postrst_press_c%0d", k), 32'(btn_press), (k == LAT) ? 32'h8 : 32'h0);
    end
    check("postrst_press_count", 32'(presses), 32'h1);
    check("postrst_level", 32'(btn_level), 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
